hazard_controller: RTL and testbench

Pipeline sequencing controller for the 5-stage rv32 core. It is the stall/flush authority for the pipeline registers: it detects load-use hazards, sequences the multi-cycle multiply/divide unit (MDU) with a start/done handshake, and freezes the pipe on data-memory wait. It also turns EX-stage branch redirects into front-end flushes and counts stall cycles. It works alongside the combinational forwarding logic, covering every hazard that forwarding cannot resolve.

---
 rtl/hazard_controller_if.sv | 53 +++++
 rtl/hazard_controller.sv | 119 +++++++++++
 tb/tb_hazard_controller.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Hazard controller bundle: pipeline-side hazard inputs and the stall/flush,
// redirect, MDU launch and stall-counter outputs.
// The controller connects through the slave modport; the pipeline driving
// hazard information connects through the master modport.
// dbg_state exposes the sequencing state: 0 = RUN, 1 = MDU_BUSY, 2 = MDU_HOLD.
// Handshake: mdu_start_o is a one-cycle launch pulse. mdu_done_i is a level
// that the MDU raises when the result is valid and holds stable until the
// next mdu_start_o. The controller consumes it only while an op is in flight.
interface hazard_controller_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1_addr_i;
    logic [4:0]       id_rs2_addr_i;
    logic             id_uses_rs1_i;
    logic             id_uses_rs2_i;
    logic [4:0]       ex_rd_i;
    logic             ex_mem_read_i;
    logic             ex_mdu_op_i;
    logic             ex_branch_taken_i;
    logic             mdu_done_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;
    logic             mdu_start_o;
    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             id_ex_stall_o;
    logic             ex_mem_stall_o;
    logic             id_ex_flush_o;
    logic             ex_mem_flush_o;
    logic             mem_wb_flush_o;
    logic             if_id_flush_o;
    logic             pc_redirect_o;
    logic [CNT_W-1:0] stall_cycles_o;
    logic [1:0]       dbg_state;

    modport slave (
        input  id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
        input  ex_rd_i, ex_mem_read_i, ex_mdu_op_i, ex_branch_taken_i,
        input  mdu_done_i, dmem_req_i, dmem_ready_i,
        output mdu_start_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
        output ex_mem_stall_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
        output if_id_flush_o, pc_redirect_o, stall_cycles_o, dbg_state
    );

    modport master (
        output id_rs1_addr_i, id_rs2_addr_i, id_uses_rs1_i, id_uses_rs2_i,
        output ex_rd_i, ex_mem_read_i, ex_mdu_op_i, ex_branch_taken_i,
        output mdu_done_i, dmem_req_i, dmem_ready_i,
        input  mdu_start_o, pc_stall_o, if_id_stall_o, id_ex_stall_o,
        input  ex_mem_stall_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
        input  if_id_flush_o, pc_redirect_o, stall_cycles_o, dbg_state
    );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush authority for the 5-stage rv32 pipeline: load-use interlock,
// multi-cycle MDU sequencing, data-memory wait freeze, branch redirect and
// a stall-cycle counter. All control outputs are combinational from the
// registered state and the current inputs; they are forced low in reset.
module hazard_controller #(
    parameter int CNT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    hazard_controller_if.slave  bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [CNT_W-1:0] stall_cnt;

    logic mem_stall;
    logic in_run;
    logic mdu_start;
    logic mdu_release;
    logic mdu_stall;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    logic branch;
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic id_ex_flush;

    // Hazard detection and stall/flush arbitration.
    always_comb begin
        mem_stall   = bus.dmem_req_i & ~bus.dmem_ready_i;
        in_run      = (state == RUN);

        // An MDU op launches only once the memory stage is not frozen.
        mdu_start   = in_run & bus.ex_mdu_op_i & ~mem_stall;

        // Release: a result seen in BUSY, or a result already parked in
        // HOLD, lets the op leave EX as soon as memory is not waiting.
        mdu_release = ~mem_stall &
                      (((state == MDU_BUSY) & bus.mdu_done_i) | (state == MDU_HOLD));

        // The front of the pipe holds from the start cycle until release.
        mdu_stall   = mdu_start | (~in_run & ~mdu_release);

        rs1_hit     = bus.id_uses_rs1_i & (bus.id_rs1_addr_i == bus.ex_rd_i);
        rs2_hit     = bus.id_uses_rs2_i & (bus.id_rs2_addr_i == bus.ex_rd_i);
        load_use    = in_run & bus.ex_mem_read_i & (bus.ex_rd_i != 5'd0) &
                      (rs1_hit | rs2_hit);

        // A taken branch squashes the younger instructions, so it wins over
        // the load-use stall; memory wait defers it entirely.
        branch      = bus.ex_branch_taken_i & ~mem_stall;

        pc_stall    = mem_stall | (~branch & (mdu_stall | load_use));
        if_id_stall = pc_stall;
        id_ex_flush = ~mem_stall & (branch | (load_use & ~mdu_stall));
        id_ex_stall = (mem_stall | mdu_stall) & ~id_ex_flush;
    end

    assign bus.mdu_start_o    = rst_ni & mdu_start;
    assign bus.pc_stall_o     = rst_ni & pc_stall;
    assign bus.if_id_stall_o  = rst_ni & if_id_stall;
    assign bus.id_ex_stall_o  = rst_ni & id_ex_stall;
    assign bus.ex_mem_stall_o = rst_ni & mem_stall;
    assign bus.id_ex_flush_o  = rst_ni & id_ex_flush;
    assign bus.ex_mem_flush_o = rst_ni & ~mem_stall & mdu_stall;
    assign bus.mem_wb_flush_o = rst_ni & mem_stall;
    assign bus.if_id_flush_o  = rst_ni & branch;
    assign bus.pc_redirect_o  = rst_ni & branch;
    assign bus.stall_cycles_o = stall_cnt;
    assign bus.dbg_state      = state;

    // MDU sequencing: launch, wait for done, park the result under memory wait.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (mdu_start) begin
                        state <= MDU_BUSY;
                    end
                end
                MDU_BUSY: begin
                    if (bus.mdu_done_i) begin
                        state <= mem_stall ? MDU_HOLD : RUN;
                    end
                end
                MDU_HOLD: begin
                    if (!mem_stall) begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Count every cycle in which the PC is held; wraps naturally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (pc_stall) begin
            stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed hazard scenarios
// followed by constrained-random traffic, all compared against a
// behavioural model of the sequencing rules.
module tb_hazard_controller;

    localparam int CNT_W = 32;
    localparam int W     = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hazard_controller_if #(.CNT_W(CNT_W)) bus ();

    hazard_controller #(.CNT_W(CNT_W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    // Behavioural model: is an MDU op in flight, has its result arrived.
    bit               m_active;
    bit               m_result;
    bit               m_fresh;
    logic [CNT_W-1:0] m_count;
    logic [W-1:0]     m_last;

    // Scoreboard comparison.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Output vector: {start, pc_st, ifid_st, idex_st, exmem_st,
    //                 idex_fl, exmem_fl, memwb_fl, ifid_fl, redirect}
    function automatic logic [W-1:0] obs_vec();
        return {bus.mdu_start_o, bus.pc_stall_o, bus.if_id_stall_o, bus.id_ex_stall_o,
                bus.ex_mem_stall_o, bus.id_ex_flush_o, bus.ex_mem_flush_o,
                bus.mem_wb_flush_o, bus.if_id_flush_o, bus.pc_redirect_o};
    endfunction

    function automatic logic model_mem();
        return bus.dmem_req_i && !bus.dmem_ready_i;
    endfunction

    function automatic logic [W-1:0] model_out();
        logic mem, br, lu, start, avail, hold, pc;
        if (!rst_n) return '0;
        mem   = model_mem();
        br    = bus.ex_branch_taken_i && !mem;
        lu    = !m_active && bus.ex_mem_read_i && (bus.ex_rd_i != 5'd0) &&
                ((bus.id_uses_rs1_i && bus.id_rs1_addr_i == bus.ex_rd_i) ||
                 (bus.id_uses_rs2_i && bus.id_rs2_addr_i == bus.ex_rd_i));
        start = !m_active && bus.ex_mdu_op_i && !mem;
        avail = m_result || bus.mdu_done_i;
        hold  = start || (m_active && !(avail && !mem));
        pc    = mem || (!br && (hold || lu));
        return {start, pc, pc, mem || (hold && !br), mem,
                br || (!mem && lu && !hold), !mem && hold, mem, br, br};
    endfunction

    function automatic logic [1:0] model_state();
        if (!m_active) return 2'd0;
        return m_result ? 2'd2 : 2'd1;
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_result = 0;
        m_fresh  = 0;
        m_count  = '0;
    endtask

    // Driver: quiet pipeline.
    task automatic idle_inputs();
        bus.id_rs1_addr_i     = 5'd0;
        bus.id_rs2_addr_i     = 5'd0;
        bus.id_uses_rs1_i     = 1'b0;
        bus.id_uses_rs2_i     = 1'b0;
        bus.ex_rd_i           = 5'd0;
        bus.ex_mem_read_i     = 1'b0;
        bus.ex_mdu_op_i       = 1'b0;
        bus.ex_branch_taken_i = 1'b0;
        bus.dmem_req_i        = 1'b0;
        bus.dmem_ready_i      = 1'b0;
    endtask

    // Driver: random but legal pipeline contents.
    task automatic rand_inputs();
        bus.id_rs1_addr_i = 5'($urandom_range(0, 3));
        bus.id_rs2_addr_i = 5'($urandom_range(0, 3));
        bus.ex_rd_i       = 5'($urandom_range(0, 3));
        bus.id_uses_rs1_i = 1'($urandom_range(0, 1));
        bus.id_uses_rs2_i = 1'($urandom_range(0, 1));
        bus.dmem_req_i    = ($urandom_range(0, 2) == 0);
        bus.dmem_ready_i  = 1'($urandom_range(0, 1));
        if (m_active) begin
            bus.ex_mdu_op_i       = 1'b1;
            bus.ex_mem_read_i     = 1'b0;
            bus.ex_branch_taken_i = 1'b0;
            if (m_fresh) bus.mdu_done_i = 1'b0;
            else if (!bus.mdu_done_i) bus.mdu_done_i = ($urandom_range(0, 3) == 0);
        end else begin
            bus.ex_mdu_op_i = ($urandom_range(0, 4) == 0);
            if (bus.ex_mdu_op_i) begin
                bus.ex_mem_read_i     = 1'b0;
                bus.ex_branch_taken_i = 1'b0;
            end else begin
                bus.ex_mem_read_i     = 1'($urandom_range(0, 1));
                bus.ex_branch_taken_i = ($urandom_range(0, 3) == 0);
            end
        end
    endtask

    // Sample outputs after inputs settle and compare against the model.
    task automatic sample(input string tag);
        #1;
        exp_q.push_back(model_out());
        m_last = exp_q[$];
        check({tag, "_outs"}, 32'(obs_vec()), 32'(exp_q.pop_front()));
        check({tag, "_state"}, 32'(bus.dbg_state), 32'(model_state()));
    endtask

    // Advance one clock, update the model, then check the counter.
    task automatic tick(input string tag);
        bit n_active, n_result, n_fresh;
        logic avail;
        n_active = m_active;
        n_result = m_result;
        n_fresh  = 0;
        avail    = m_result || bus.mdu_done_i;
        if (rst_n) begin
            if (!m_active && bus.ex_mdu_op_i && !model_mem()) begin
                n_active = 1;
                n_result = 0;
                n_fresh  = 1;
            end else if (m_active) begin
                if (avail && !model_mem()) begin
                    n_active = 0;
                    n_result = 0;
                end else if (bus.mdu_done_i) begin
                    n_result = 1;
                end
            end
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            m_active = n_active;
            m_result = n_result;
            m_fresh  = n_fresh;
            if (m_last[8]) m_count = m_count + 1;
        end
        @(negedge clk);
        check({tag, "_cnt"}, bus.stall_cycles_o, m_count);
    endtask

    task automatic cyc(input string tag);
        sample(tag);
        tick(tag);
    endtask

    initial begin
        idle_inputs();
        bus.mdu_done_i = 1'b0;
        model_reset();
        m_last = '0;

        // Reset: aggressive inputs must not leak through.
        @(negedge clk);
        bus.ex_mdu_op_i = 1'b1;
        bus.ex_branch_taken_i = 1'b1;
        bus.dmem_req_i = 1'b1;
        sample("reset");
        check("reset_all_zero", 32'(obs_vec()), 32'd0);
        check("reset_cnt", bus.stall_cycles_o, 32'd0);
        tick("reset");
        idle_inputs();
        rst_n = 1'b1;
        cyc("idle");

        // Load-use through rs2: one stall cycle.
        bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd5;
        bus.id_rs2_addr_i = 5'd5; bus.id_uses_rs2_i = 1'b1;
        bus.id_rs1_addr_i = 5'd3; bus.id_uses_rs1_i = 1'b1;
        sample("lu");
        check("lu_pc_stall", 32'(bus.pc_stall_o), 32'd1);
        check("lu_if_id_stall", 32'(bus.if_id_stall_o), 32'd1);
        check("lu_id_ex_flush", 32'(bus.id_ex_flush_o), 32'd1);
        tick("lu");
        check("lu_cnt_one", bus.stall_cycles_o, 32'd1);
        idle_inputs();
        sample("lu_after");
        check("lu_after_zero", 32'(obs_vec()), 32'd0);
        tick("lu_after");

        // MDU op: stalls cover cycles 0-4, result arrives in cycle 5.
        bus.ex_mdu_op_i = 1'b1;
        sample("mdu0");
        check("mdu_start_c0", 32'(bus.mdu_start_o), 32'd1);
        tick("mdu0");
        for (int i = 1; i <= 4; i++) begin
            sample("mdu_busy");
            check("mdu_no_restart", 32'(bus.mdu_start_o), 32'd0);
            check("mdu_busy_stall", 32'({bus.pc_stall_o, bus.if_id_stall_o,
                  bus.id_ex_stall_o, bus.ex_mem_flush_o}), 32'hF);
            tick("mdu_busy");
        end
        bus.mdu_done_i = 1'b1;
        sample("mdu_rel");
        check("mdu_release_zero", 32'(obs_vec()), 32'd0);
        tick("mdu_rel");
        check("mdu_cnt_plus5", bus.stall_cycles_o, 32'd6);
        bus.ex_mdu_op_i = 1'b0;
        cyc("mdu_after");

        // MDU result arrives during a 3-cycle memory wait.
        bus.ex_mdu_op_i = 1'b1;
        cyc("hold_start");
        bus.mdu_done_i = 1'b0;
        cyc("hold_busy");
        bus.mdu_done_i = 1'b1;
        bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample("hold_wait");
            check("hold_stalls", 32'(obs_vec()), 32'b0111100100);
            tick("hold_wait");
            check("hold_state", 32'(bus.dbg_state), 32'd2);
        end
        bus.dmem_ready_i = 1'b1;
        sample("hold_rel");
        check("hold_release_zero", 32'(obs_vec()), 32'd0);
        tick("hold_rel");
        check("hold_cnt", bus.stall_cycles_o, 32'd11);
        idle_inputs();
        sample("hold_after");
        check("hold_no_second_start", 32'(bus.mdu_start_o), 32'd0);
        tick("hold_after");

        // Branch with a load-use present, then under memory wait.
        bus.ex_mem_read_i = 1'b1; bus.ex_rd_i = 5'd7;
        bus.id_rs1_addr_i = 5'd7; bus.id_uses_rs1_i = 1'b1;
        bus.ex_branch_taken_i = 1'b1;
        sample("br");
        check("br_vec", 32'(obs_vec()), 32'b0000010011);
        tick("br");
        bus.dmem_req_i = 1'b1; bus.dmem_ready_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample("br_mem");
            check("br_mem_no_redirect", 32'({bus.pc_redirect_o, bus.if_id_flush_o,
                  bus.id_ex_flush_o}), 32'd0);
            tick("br_mem");
        end
        bus.dmem_ready_i = 1'b1;
        sample("br_ready");
        check("br_ready_redirect", 32'(bus.pc_redirect_o), 32'd1);
        tick("br_ready");

        // Load to x0 never interlocks.
        idle_inputs();
        bus.ex_mem_read_i = 1'b1;
        bus.id_uses_rs1_i = 1'b1; bus.id_uses_rs2_i = 1'b1;
        sample("x0");
        check("x0_no_stall", 32'(obs_vec()), 32'd0);
        tick("x0");

        // Reset asserted while the MDU is busy, then a stale done.
        idle_inputs();
        bus.mdu_done_i = 1'b0;
        bus.ex_mdu_op_i = 1'b1;
        cyc("rst_start");
        sample("rst_busy");
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_outs_zero", 32'(obs_vec()), 32'd0);
        check("rst_cnt_zero", bus.stall_cycles_o, 32'd0);
        @(negedge clk);
        idle_inputs();
        bus.mdu_done_i = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            sample("stale_done");
            check("stale_no_stall", 32'(obs_vec()), 32'd0);
            tick("stale_done");
        end

        // Constrained-random traffic.
        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
